// File: rtl/or_compare_checker.sv
// Exhaustive sweep engine comparing a direct N-input OR against a chained
// 2-input OR, both checked against an internal OR-reduction.
module or_compare_checker #(
    parameter int N_IN       = 3,
    parameter int SETTLE_CYC = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            dut_out_a,
    input  logic            dut_out_b,
    output logic [N_IN-1:0] vec,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_err_vec,
    output logic            first_err_valid
);

    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE_CYC - 1);
    localparam logic [N_IN-1:0] ALL_ONES    = '1;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          golden;
    logic          agree;

    assign golden = |vec;
    // Written as a positive match so an unknown response falls to the
    // mismatch branch below.
    assign agree  = (dut_out_a == golden) && (dut_out_b == golden);
    assign pass   = done && (err_count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            vec             <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        vec             <= '0;
                        err_count       <= '0;
                        first_err_vec   <= '0;
                        first_err_valid <= 1'b0;
                        cnt             <= SETTLE_LOAD;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        state           <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                SAMPLE: begin
                    if (agree) begin
                        err_count <= err_count;
                    end else begin
                        err_count <= err_count + (N_IN + 1)'(1);
                        if (!first_err_valid) begin
                            first_err_vec   <= vec;
                            first_err_valid <= 1'b1;
                        end
                    end
                    // The all-ones vector ends the sweep instead of wrapping.
                    if (vec == ALL_ONES) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        vec   <= vec + N_IN'(1);
                        cnt   <= SETTLE_LOAD;
                        state <= SETTLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_or_compare_checker.sv
// Bench for or_compare_checker: sweep-level model plus directed scenarios
// on an N_IN=3/SETTLE_CYC=1 and an N_IN=4/SETTLE_CYC=3 instance.
module tb_or_compare_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start3 = 1'b0;
    logic start4 = 1'b0;
    int   mode3 = 0;
    int   mode4 = 0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // Fault modes: 0 correct, 1 out_b stuck-at-0, 2 out_a forced 1 at vec 0
    function automatic logic fa(int v, int mode);
        if (mode == 2 && v == 0) return 1'b1;
        return v != 0;
    endfunction

    function automatic logic fb(int v, int mode);
        if (mode == 1) return 1'b0;
        return v != 0;
    endfunction

    function automatic bit mism(int v, int mode);
        logic g;
        g = (v != 0);
        return (fa(v, mode) != g) || (fb(v, mode) != g);
    endfunction

    function automatic int mcount(int mode, int nv);
        int c;
        c = 0;
        for (int v = 0; v < nv; v++) if (mism(v, mode)) c++;
        return c;
    endfunction

    function automatic int mfirst(int mode, int nv);
        for (int v = 0; v < nv; v++) if (mism(v, mode)) return v;
        return -1;
    endfunction

    logic [2:0] vec3;
    logic       busy3, done3, pass3, fv3_valid;
    logic [3:0] err3;
    logic [2:0] fv3;
    logic       a3, b3;

    logic [3:0] vec4;
    logic       busy4, done4, pass4, fv4_valid;
    logic [4:0] err4;
    logic [3:0] fv4;
    logic       a4, b4;

    assign a3 = fa(int'(vec3), mode3);
    assign b3 = fb(int'(vec3), mode3);
    assign a4 = fa(int'(vec4), mode4);
    assign b4 = fb(int'(vec4), mode4);

    or_compare_checker #(.N_IN(3), .SETTLE_CYC(1)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3),
        .dut_out_a(a3), .dut_out_b(b3),
        .vec(vec3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .first_err_vec(fv3),
        .first_err_valid(fv3_valid)
    );

    or_compare_checker #(.N_IN(4), .SETTLE_CYC(3)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4),
        .dut_out_a(a4), .dut_out_b(b4),
        .vec(vec4), .busy(busy4), .done(done4), .pass(pass4),
        .err_count(err4), .first_err_vec(fv4),
        .first_err_valid(fv4_valid)
    );

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 sweeping, 2 done; t = edges since start
    int ph3 = 0, t3 = 0, m3 = 0;
    int ph4 = 0, t4 = 0, m4 = 0;
    bit armed3 = 0, armed4 = 0;

    always @(posedge clk) begin
        if (rst) begin
            ph3 = 0; t3 = 0; armed3 = 1;
        end else if (ph3 != 1 && start3) begin
            ph3 = 1; t3 = 0; m3 = mode3;
        end else if (ph3 == 1) begin
            t3++;
            if (t3 == 8 * 2) ph3 = 2;
        end
        if (rst) begin
            ph4 = 0; t4 = 0; armed4 = 1;
        end else if (ph4 != 1 && start4) begin
            ph4 = 1; t4 = 0; m4 = mode4;
        end else if (ph4 == 1) begin
            t4++;
            if (t4 == 16 * 4) ph4 = 2;
        end
    end

    task automatic check_dut(string tag, int n, int s, int mode, int ph,
                             int t, int vec, int busy, int done, int pass,
                             int err, int fv, int fvalid);
        int nv, evec, eerr, f;
        nv   = (ph == 2) ? (1 << n) : (ph == 1) ? t / (s + 1) : 0;
        evec = (ph == 2) ? (1 << n) - 1 : nv;
        eerr = mcount(mode, nv);
        f    = mfirst(mode, nv);
        chk({tag, ".vec"}, vec, evec);
        chk({tag, ".busy"}, busy, int'(ph == 1));
        chk({tag, ".done"}, done, int'(ph == 2));
        chk({tag, ".pass"}, pass, int'(ph == 2 && eerr == 0));
        chk({tag, ".err"}, err, eerr);
        chk({tag, ".fvalid"}, fvalid, int'(f >= 0));
        chk({tag, ".fvec"}, fv, (f >= 0) ? f : 0);
    endtask

    always @(negedge clk) begin
        if (armed3)
            check_dut("m3", 3, 1, m3, ph3, t3, int'(vec3), int'(busy3),
                      int'(done3), int'(pass3), int'(err3), int'(fv3),
                      int'(fv3_valid));
        if (armed4)
            check_dut("m4", 4, 3, m4, ph4, t4, int'(vec4), int'(busy4),
                      int'(done4), int'(pass4), int'(err4), int'(fv4),
                      int'(fv4_valid));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done3(input int from, output int n);
        n = from;
        while (!done3 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic sweep3(int mode, output int n);
        mode3 = mode;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        wait_done3(0, n);
    endtask

    initial begin
        int n;
        tick();
        tick();
        rst = 1'b0;
        chk("rst.vec", int'(vec3), 0);
        chk("rst.busy", int'(busy3), 0);
        chk("rst.done", int'(done3), 0);
        chk("rst.pass", int'(pass3), 0);
        chk("rst.err", int'(err3), 0);
        chk("rst.fvalid", int'(fv3_valid), 0);

        sweep3(0, n);
        chk("clean.latency", n, 16);
        chk("clean.pass", int'(pass3), 1);
        chk("clean.err", int'(err3), 0);
        chk("clean.fvalid", int'(fv3_valid), 0);

        sweep3(1, n);
        chk("stuckb.latency", n, 16);
        chk("stuckb.err", int'(err3), 7);
        chk("stuckb.fvec", int'(fv3), 1);
        chk("stuckb.fvalid", int'(fv3_valid), 1);
        chk("stuckb.pass", int'(pass3), 0);

        sweep3(2, n);
        chk("forcea.err", int'(err3), 1);
        chk("forcea.fvec", int'(fv3), 0);
        chk("forcea.fvalid", int'(fv3_valid), 1);
        chk("forcea.pass", int'(pass3), 0);

        mode3 = 0;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        repeat (4) tick();
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        wait_done3(5, n);
        chk("ignore.latency", n, 16);
        chk("ignore.err", int'(err3), 0);
        chk("ignore.pass", int'(pass3), 1);

        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        chk("restart.vec", int'(vec3), 0);
        chk("restart.busy", int'(busy3), 1);
        chk("restart.done", int'(done3), 0);
        repeat (8) tick();
        chk("mid.vec", int'(vec3), 4);
        chk("mid.busy", int'(busy3), 1);
        rst = 1'b1;
        start3 = 1'b1;
        tick();
        rst = 1'b0;
        start3 = 1'b0;
        chk("midrst.vec", int'(vec3), 0);
        chk("midrst.busy", int'(busy3), 0);
        chk("midrst.done", int'(done3), 0);
        tick();
        chk("idle.busy", int'(busy3), 0);

        sweep3(0, n);
        chk("after_rst.latency", n, 16);
        chk("after_rst.pass", int'(pass3), 1);

        mode4 = 0;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        n = 0;
        while (!done4 && n < 500) begin
            tick();
            n++;
        end
        chk("wide.latency", n, 64);
        chk("wide.pass", int'(pass4), 1);
        chk("wide.err", int'(err4), 0);
        chk("wide.vec", int'(vec4), 15);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
